// File: rtl/iter_shift_unit_if.sv
// Bus bundle between the control unit (master) and iter_shift_unit (slave).
// Carry/zero status signals exist only when SHIFT_STATUS_EN is defined.
interface iter_shift_unit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
`ifdef SHIFT_STATUS_EN
    logic             carry;
    logic             zero;

    modport master (output start, op, a, b, input busy, done, result, carry, zero);
    modport slave  (input start, op, a, b, output busy, done, result, carry, zero);
`else
    modport master (output start, op, a, b, input busy, done, result);
    modport slave  (input start, op, a, b, output busy, done, result);
`endif
endinterface

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: SLL/SRL/SRA/ROL/ROR by b[AW-1:0], up to STEP bits per clock.
// Optional carry/zero status outputs are built when SHIFT_STATUS_EN is defined.
module iter_shift_unit #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               reset,
    iter_shift_unit_if.slave   bus
);
    localparam int AW = $clog2(WIDTH);
    localparam logic [AW:0] STEP_L = (AW+1)'(STEP);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic [AW-1:0]    s;
    logic [AW-1:0]    inv_s;
    logic [WIDTH-1:0] shl_v, shr_v, sra_v, rol_v, ror_v;
    logic [WIDTH-1:0] tmp_hi, tmp_lo;
    logic             msb_out, lsb_out;
    logic             unused_b_hi;

    assign unused_b_hi = ^bus.b[WIDTH-1:AW];

    always_comb begin
        // Per-step amount s = min(STEP, counter); inv_s is its complement modulo WIDTH.
        s      = ({1'b0, cnt_q} < STEP_L) ? cnt_q : STEP_L[AW-1:0];
        inv_s  = AW'(WIDTH - int'(s));
        shl_v  = result_q << s;
        shr_v  = result_q >> s;
        sra_v  = WIDTH'($signed(result_q) >>> s);
        rol_v  = (result_q << s) | (result_q >> inv_s);
        ror_v  = (result_q >> s) | (result_q << inv_s);
        tmp_hi = result_q >> inv_s;
        tmp_lo = result_q >> (s - 1'b1);
        msb_out = tmp_hi[0];
        lsb_out = tmp_lo[0];

        state_d  = state_q;
        result_d = result_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        zero_d   = zero_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    result_d = bus.a;
                    op_d     = bus.op;
                    cnt_d    = bus.b[AW-1:0];
                    carry_d  = 1'b0;
                    if (bus.b[AW-1:0] == '0 || bus.op > OP_ROR) begin
                        state_d = S_DONE;
                        zero_d  = (bus.a == '0);
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q - s;
                case (op_q)
                    OP_SLL: begin result_d = shl_v; carry_d = msb_out; end
                    OP_SRL: begin result_d = shr_v; carry_d = lsb_out; end
                    OP_SRA: begin result_d = sra_v; carry_d = lsb_out; end
                    OP_ROL: begin result_d = rol_v; carry_d = msb_out; end
                    OP_ROR: begin result_d = ror_v; carry_d = lsb_out; end
                    default: result_d = result_q;
                endcase
                if (cnt_q == s) begin
                    state_d = S_DONE;
                    zero_d  = (result_d == '0);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
`ifdef SHIFT_STATUS_EN
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;
`else
    logic unused_status;
    assign unused_status = carry_q ^ zero_q;
`endif

endmodule
